// File: rtl/mem_stage_ctrl_if.sv
// mem_stage_ctrl_if: request/acknowledge bus between the M-stage controller and data memory.
// The controller drives the request side (master); the memory answers with mem_ack (slave).
interface mem_stage_ctrl_if;
   logic       mem_req;
   logic       mem_we;
   logic [3:0] byte_en;
   logic       mem_ack;

   modport master (
      output mem_req,
      output mem_we,
      output byte_en,
      input  mem_ack
   );

   modport slave (
      input  mem_req,
      input  mem_we,
      input  byte_en,
      output mem_ack
   );
endinterface

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: M-stage control unit. Holds the E->M pipeline register, decodes MIPS
// loads/stores into a load code and byte enables, and runs an IDLE/ACCESS request FSM
// toward a variable-latency data memory with an optional cycle-count timeout.
// Optional feature: define MISALIGN_TRAP_EN to flag misaligned word/half accesses and
// suppress their memory request; otherwise the low address bits are masked.
module mem_stage_ctrl #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       Instr_E,
   input  logic              CMPrst_E,
   input  logic [ADDR_W-1:0] Addr_E,
   input  logic              flush,
   mem_stage_ctrl_if.master  mem,
   output logic [2:0]        Load,
   output logic [31:0]       Instr_M,
   output logic              CMPrst_M,
   output logic [ADDR_W-1:0] Addr_M,
   output logic              stall,
   output logic              bus_err,
   output logic              misalign
);

   typedef enum logic {StIdle, StAccess} state_e;
   typedef enum logic [1:0] {SzNone, SzByte, SzHalf, SzWord} size_e;

   localparam bit               TimeoutEn = (TIMEOUT != 0);
   localparam logic [CNT_W-1:0] CntLast   = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   function automatic size_e op_size(input logic [5:0] op);
      case (op)
         6'h23, 6'h2B:        op_size = SzWord;
         6'h21, 6'h25, 6'h29: op_size = SzHalf;
         6'h20, 6'h24, 6'h28: op_size = SzByte;
         default:             op_size = SzNone;
      endcase
   endfunction

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [5:0]       op_e;
   size_e            sz_m;
   size_e            sz_e;
   logic             trap_m;
   logic             enter_e;
   logic             timeout;
   logic [1:0]       a_m;
   logic [3:0]       be_m;

   // A flushed slot carries opcode 0, so it can never start an access.
   assign op_e = flush ? 6'd0 : Instr_E[31:26];
   assign sz_e = op_size(op_e);
   assign sz_m = op_size(Instr_M[31:26]);

`ifdef MISALIGN_TRAP_EN
   function automatic logic op_misaligned(input size_e sz, input logic [1:0] a);
      case (sz)
         SzWord:  op_misaligned = (a != 2'b00);
         SzHalf:  op_misaligned = a[0];
         default: op_misaligned = 1'b0;
      endcase
   endfunction

   assign trap_m  = op_misaligned(sz_m, Addr_M[1:0]);
   assign enter_e = (sz_e != SzNone) && !op_misaligned(sz_e, Addr_E[1:0]);
   assign a_m     = Addr_M[1:0];
`else
   assign trap_m  = 1'b0;
   assign enter_e = (sz_e != SzNone);

   // Without the trap, force natural alignment before lane selection.
   always_comb begin
      a_m = Addr_M[1:0];
      case (sz_m)
         SzWord:  a_m = 2'b00;
         SzHalf:  a_m = {Addr_M[1], 1'b0};
         default: a_m = Addr_M[1:0];
      endcase
   end
`endif

   assign misalign = trap_m;

   // Load code straight from the registered opcode, independent of FSM state.
   always_comb begin
      Load = 3'd0;
      case (Instr_M[31:26])
         6'h23:   Load = 3'd1;
         6'h21:   Load = 3'd2;
         6'h25:   Load = 3'd3;
         6'h20:   Load = 3'd4;
         6'h24:   Load = 3'd5;
         default: Load = 3'd0;
      endcase
   end

   // Byte lane enables; loads and stores share the same lane rule.
   always_comb begin
      be_m = 4'b0000;
      if (!trap_m) begin
         case (sz_m)
            SzWord:  be_m = 4'b1111;
            SzHalf:  be_m = a_m[1] ? 4'b1100 : 4'b0011;
            SzByte:  be_m = 4'b0001 << a_m;
            default: be_m = 4'b0000;
         endcase
      end
   end

   assign timeout     = TimeoutEn && (state_q == StAccess) && !mem.mem_ack && (cnt_q == CntLast);
   assign stall       = (state_q == StAccess) && !mem.mem_ack && !timeout;
   assign bus_err     = timeout;
   assign mem.mem_req = (state_q == StAccess);
   // Store opcodes are the memory opcodes with bit 29 set.
   assign mem.mem_we  = mem.mem_req && (sz_m != SzNone) && Instr_M[29];
   assign mem.byte_en = be_m;

   // M pipeline register and request FSM; they advance together whenever not stalled.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         Instr_M  <= '0;
         CMPrst_M <= 1'b0;
         Addr_M   <= '0;
      end else if (stall) begin
         cnt_q <= cnt_q + 1'b1;
      end else begin
         if (flush) begin
            Instr_M  <= '0;
            CMPrst_M <= 1'b0;
            Addr_M   <= '0;
         end else begin
            Instr_M  <= Instr_E;
            CMPrst_M <= CMPrst_E;
            Addr_M   <= Addr_E;
         end
         cnt_q   <= '0;
         state_q <= enter_e ? StAccess : StIdle;
      end
   end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Parametrised successor to the M-stage control unit.
- Holds the E→M pipeline register (instruction, compare result, address).
- Decodes the full MIPS load/store set (lw/lh/lhu/lb/lbu/sw/sh/sb) into a load code and byte enables.
- Runs a request/acknowledge FSM toward a variable-latency data memory, stalling the pipeline until the access completes or times out.

Parameters:
- ADDR_W, 32, width of the effective address carried through the M stage
- TIMEOUT, 16, maximum ACCESS cycles before abort; 0 disables the timeout
- CNT_W, 5, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset; 0 = reset
- Instr_E  input  32  instruction leaving the E stage
- CMPrst_E  input  1  compare result from the E stage
- Addr_E  input  ADDR_W  effective address from the E-stage ALU
- flush  input  1  load a NOP into M instead of the E values
- mem_ack  input  1  memory completes the current access this cycle
- mem_req  output  1  access request, held until ack or timeout
- mem_we  output  1  write strobe; qualified by mem_req
- byte_en  output  4  byte lane enables for the current access
- Load  output  3  load code: 0 none, 1 lw, 2 lh, 3 lhu, 4 lb, 5 lbu
- Instr_M  output  32  registered instruction
- CMPrst_M  output  1  registered compare result
- Addr_M  output  ADDR_W  registered address
- stall  output  1  freeze F/D/E and the M register
- bus_err  output  1  one-cycle pulse when an access times out
- misalign  output  1  misaligned access flag; driven 0 when MISALIGN_TRAP_EN is undefined

Behaviour:
- Reset (reset=0, asynchronous):
  - Instr_M, CMPrst_M, Addr_M and the wait counter clear to 0; state = IDLE.
  - All outputs are 0 during reset.
- Decode on Instr_M[31:26]:
  - lw 0x23, lh 0x21, lhu 0x25, lb 0x20, lbu 0x24, sw 0x2B, sh 0x29, sb 0x28.
  - Any other opcode is a non-memory instruction: Load=0, byte_en=0.
  - Load is combinational from Instr_M and independent of state.
- Byte enables, using a = Addr_M[1:0]:
  - word: 4'b1111
  - half: a[1] ? 4'b1100 : 4'b0011
  - byte: 4'b0001 << a
  - Loads and stores use the same rule.
- M register update on posedge clk:
  - stall=1: hold.
  - else flush=1: Instr_M=0, CMPrst_M=0, Addr_M=0.
  - else: load the E values.
  - Flush is ignored while stall=1.
- FSM states IDLE and ACCESS:
  - IDLE→ACCESS at the edge where a memory instruction is loaded into M (unless misalign-trapped).
  - ACCESS: mem_req=1; mem_we=1 for sw/sh/sb.
  - ACCESS→IDLE on mem_ack=1 or on timeout. At the same edge the M register accepts the next instruction; a back-to-back memory instruction re-enters ACCESS with no idle cycle.
  - mem_ack is ignored in IDLE.
- Stall and latency:
  - stall = ACCESS & ~mem_ack & ~timeout, combinational.
  - Ack in the first ACCESS cycle gives zero stall cycles.
  - Each extra wait cycle adds one stall cycle.
- Timeout:
  - The wait counter clears on entering ACCESS and increments each ACCESS cycle without ack.
  - timeout = (TIMEOUT!=0) & ACCESS & ~mem_ack & (cnt==TIMEOUT-1).
  - bus_err = timeout: one-cycle pulse, stall deasserts the same cycle, state→IDLE.
  - The instruction retires; the write is considered dropped.
- Reset mid-access: the FSM returns to IDLE immediately and mem_req drops asynchronously.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - Misaligned means lw/sw with Addr_M[1:0]!=0, or lh/lhu/sh with Addr_M[0]!=0.
  - A misaligned instruction asserts misalign for as long as it occupies M.
  - It never enters ACCESS, and no mem_req or stall is generated.
  - byte_en=0 while misalign=1.
- Undefined:
  - misalign is tied 0.
  - The low address bits are masked before byte-enable generation (word: a=00; half: a[0]=0).
  - The access proceeds normally.

Test Plan:
- Reset and fetch: reset low 3 cycles, then Instr_E=0x8C000000 (lw), Addr_E=0x10 → next cycle Load=1, mem_req=1, byte_en=1111, mem_we=0; mem_ack=1 same cycle → stall never asserts.
- Wait states: sh with Addr_E=0x1002 and ack after 3 ACCESS cycles → stall=1 for exactly 2 cycles, byte_en=1100, mem_we=1; Instr_M holds across the stall.
- Back-to-back: sb @0x3 then lbu @0x1, both acked immediately → byte_en 1000 then 0010, Load 0→5, mem_req high 2 consecutive cycles.
- Timeout (TIMEOUT=4): sw with no ack → stall high 3 cycles, bus_err pulses 1 cycle in the 4th, then state IDLE and the next instruction loads.
- Flush/stall and async reset: flush=1 during a stalled lw → Instr_M unchanged; flush=1 while idle → Instr_M=0. Reset low mid-ACCESS → mem_req=0 before the next edge.
- Misalign: lw @0x2 → with MISALIGN_TRAP_EN misalign=1, mem_req=0, stall=0; without it byte_en=1111 and the request is issued.
